sad_candidate_generator: RTL and testbench

- Producer side of the minimum-SAD tracking path: walks every candidate position of a search window and computes the sum of absolute differences (SAD) between the reference block and each candidate.
- Emits one (SAD, row, column) result per candidate to the downstream minimum-SAD register.
- Pixel pairs arrive serially from the frame/window memory. The block drives the current candidate row, column and pixel index so upstream can generate addresses.

---
 rtl/sad_candidate_generator.sv | 214 +++++++++++++++++++++
 tb/tb_sad_candidate_generator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_candidate_generator.sv
`default_nettype none
// ============================================================================
// Module      : sad_candidate_generator
// Description : Walks every candidate position of a search window and sums
//               the absolute pixel differences between the reference block
//               and each candidate. Emits one (SAD, row, column) result per
//               candidate over a valid/ready handshake.
//
// Ports       : Clk, Rst          clock, synchronous active-high reset
//               Start             begins a full window scan (IDLE only)
//               PixValid/PixReady pixel-pair handshake (FramePix, WindowPix)
//               CurRow/CurColumn  candidate position being accumulated
//               PixIndex          next expected pixel index inside the block
//               SADValid/SADReady result handshake
//               SADOut            SAD of the emitted candidate
//               SADRowOut/SADColumnOut  position of the emitted candidate
//               Busy              high whenever the scan FSM is not idle
//               Done              one-cycle pulse after the last result
//
// Options     : SAD_SATURATE_EN  when defined, the accumulator clamps at
//                                32767 instead of wrapping modulo 2^32.
//
// Revision    : 1.0  initial release
// ============================================================================
module sad_candidate_generator #(
    parameter int PIX_W       = 8,
    parameter int BLOCK_W     = 4,
    parameter int BLOCK_H     = 4,
    parameter int SEARCH_ROWS = 16,
    parameter int SEARCH_COLS = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             PixValid,
    output logic             PixReady,
    input  logic [PIX_W-1:0] FramePix,
    input  logic [PIX_W-1:0] WindowPix,
    output logic [7:0]       CurRow,
    output logic [7:0]       CurColumn,
    output logic [15:0]      PixIndex,
    output logic             SADValid,
    input  logic             SADReady,
    output logic [31:0]      SADOut,
    output logic [7:0]       SADRowOut,
    output logic [7:0]       SADColumnOut,
    output logic             Busy,
    output logic             Done
);

    localparam logic [15:0] c_LAST_IDX = 16'(BLOCK_W * BLOCK_H - 1);
    localparam logic [7:0]  c_LAST_ROW = 8'(SEARCH_ROWS - 1);
    localparam logic [7:0]  c_LAST_COL = 8'(SEARCH_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0]  r_acc;
    logic [7:0]   r_row;
    logic [7:0]   r_col;
    logic [15:0]  r_pix_idx;

    logic         w_pix_hs;
    logic         w_sad_hs;
    logic         w_last_pix;
    logic         w_last_cand;
    logic [PIX_W:0] w_diff;
    logic [31:0]  w_diff_ext;
    logic [31:0]  w_acc_next;

    // ------------------------------------------------------------------
    // Handshake and position qualifiers
    // ------------------------------------------------------------------
    assign w_pix_hs    = (r_state == S_ACCUM) && PixValid;
    assign w_sad_hs    = (r_state == S_EMIT) && SADReady;
    assign w_last_pix  = (r_pix_idx == c_LAST_IDX);
    assign w_last_cand = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    // ------------------------------------------------------------------
    // Absolute difference, computed one bit wider so the subtraction of
    // the smaller operand from the larger never borrows.
    // ------------------------------------------------------------------
    always_comb begin
        w_diff = '0;
        if (FramePix >= WindowPix) begin
            w_diff = {1'b0, FramePix} - {1'b0, WindowPix};
        end else begin
            w_diff = {1'b0, WindowPix} - {1'b0, FramePix};
        end
    end

    assign w_diff_ext = 32'(w_diff);

`ifdef SAD_SATURATE_EN
    // The accumulator never holds more than 32767, so a 33-bit sum cannot
    // overflow and a single compare decides the clamp.
    logic [32:0] w_sum;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_diff_ext};
    assign w_acc_next = (w_sum > 33'd32767) ? 32'd32767 : w_sum[31:0];
`else
    assign w_acc_next = r_acc + w_diff_ext;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_pix_hs && w_last_pix) begin
                    w_next_state = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_sad_hs) begin
                    w_next_state = w_last_cand ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, pixel index and candidate position
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_acc     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pix_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_acc     <= '0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_pix_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_pix_hs) begin
                        r_acc     <= w_acc_next;
                        // Index returns to zero once the block is complete
                        // so it never leaves the 0..N-1 range.
                        r_pix_idx <= w_last_pix ? 16'd0 : r_pix_idx + 16'd1;
                    end
                end
                S_EMIT: begin
                    // Accumulator is held through EMIT because it drives
                    // SADOut directly; only clear it once the result leaves.
                    if (w_sad_hs && !w_last_cand) begin
                        r_acc     <= '0;
                        r_pix_idx <= '0;
                        if (r_col == c_LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 8'd1;
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PixReady     = (r_state == S_ACCUM);
    assign SADValid     = (r_state == S_EMIT);
    assign SADOut       = r_acc;
    assign SADRowOut    = r_row;
    assign SADColumnOut = r_col;
    assign CurRow       = r_row;
    assign CurColumn    = r_col;
    assign PixIndex     = r_pix_idx;
    assign Busy         = (r_state != S_IDLE);
    assign Done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sad_candidate_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_candidate_generator
// Description : Directed self-checking bench. Instance A uses a 2x2 block
//               over a 2x3 search window; instances B (16x16 block) and
//               C (4x4 block) use a 1x1 search window and share inputs for
//               the large-sum / saturation cases (SAD_SATURATE_EN aware).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sad_candidate_generator;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_bc = 1'b0;
    logic        PixValid = 1'b0;
    logic [7:0]  FramePix = '0;
    logic [7:0]  WindowPix = '0;
    logic        sad_ready_a = 1'b0;
    logic        sad_ready_bc = 1'b0;

    logic        a_pix_ready, a_sad_valid, a_busy, a_done;
    logic [7:0]  a_cur_row, a_cur_col, a_row_out, a_col_out;
    logic [15:0] a_pix_index;
    logic [31:0] a_sad_out;

    logic        b_pix_ready, b_sad_valid, b_busy, b_done;
    logic [7:0]  b_cur_row, b_cur_col, b_row_out, b_col_out;
    logic [15:0] b_pix_index;
    logic [31:0] b_sad_out;

    logic        c_pix_ready, c_sad_valid, c_busy, c_done;
    logic [7:0]  c_cur_row, c_cur_col, c_row_out, c_col_out;
    logic [15:0] c_pix_index;
    logic [31:0] c_sad_out;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] fa [4];
    logic [7:0] wa [4];

    always #5 Clk = ~Clk;

    sad_candidate_generator #(
        .PIX_W(8), .BLOCK_W(2), .BLOCK_H(2), .SEARCH_ROWS(2), .SEARCH_COLS(3)
    ) u_dut_a (
        .Clk(Clk), .Rst(Rst), .Start(start_a), .PixValid(PixValid),
        .PixReady(a_pix_ready), .FramePix(FramePix), .WindowPix(WindowPix),
        .CurRow(a_cur_row), .CurColumn(a_cur_col), .PixIndex(a_pix_index),
        .SADValid(a_sad_valid), .SADReady(sad_ready_a), .SADOut(a_sad_out),
        .SADRowOut(a_row_out), .SADColumnOut(a_col_out),
        .Busy(a_busy), .Done(a_done)
    );

    sad_candidate_generator #(
        .PIX_W(8), .BLOCK_W(16), .BLOCK_H(16), .SEARCH_ROWS(1), .SEARCH_COLS(1)
    ) u_dut_b (
        .Clk(Clk), .Rst(Rst), .Start(start_bc), .PixValid(PixValid),
        .PixReady(b_pix_ready), .FramePix(FramePix), .WindowPix(WindowPix),
        .CurRow(b_cur_row), .CurColumn(b_cur_col), .PixIndex(b_pix_index),
        .SADValid(b_sad_valid), .SADReady(sad_ready_bc), .SADOut(b_sad_out),
        .SADRowOut(b_row_out), .SADColumnOut(b_col_out),
        .Busy(b_busy), .Done(b_done)
    );

    sad_candidate_generator #(
        .PIX_W(8), .BLOCK_W(4), .BLOCK_H(4), .SEARCH_ROWS(1), .SEARCH_COLS(1)
    ) u_dut_c (
        .Clk(Clk), .Rst(Rst), .Start(start_bc), .PixValid(PixValid),
        .PixReady(c_pix_ready), .FramePix(FramePix), .WindowPix(WindowPix),
        .CurRow(c_cur_row), .CurColumn(c_cur_col), .PixIndex(c_pix_index),
        .SADValid(c_sad_valid), .SADReady(sad_ready_bc), .SADOut(c_sad_out),
        .SADRowOut(c_row_out), .SADColumnOut(c_col_out),
        .Busy(c_busy), .Done(c_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_a();
        chk("rst_pixready", 32'(a_pix_ready), 0);
        chk("rst_sadvalid", 32'(a_sad_valid), 0);
        chk("rst_sadout",   a_sad_out, 0);
        chk("rst_rowout",   32'(a_row_out), 0);
        chk("rst_colout",   32'(a_col_out), 0);
        chk("rst_currow",   32'(a_cur_row), 0);
        chk("rst_curcol",   32'(a_cur_col), 0);
        chk("rst_pixindex", 32'(a_pix_index), 0);
        chk("rst_busy",     32'(a_busy), 0);
        chk("rst_done",     32'(a_done), 0);
    endtask

    // Feed the four pairs in fa/wa to instance A, checking the ACCUM view.
    task automatic feed_a(input int erow, input int ecol, input bit pulse_start);
        for (int i = 0; i < 4; i++) begin
            chk("accum_pixready", 32'(a_pix_ready), 1);
            chk("accum_pixindex", 32'(a_pix_index), 32'(i));
            chk("accum_currow",   32'(a_cur_row), 32'(erow));
            chk("accum_curcol",   32'(a_cur_col), 32'(ecol));
            FramePix  = fa[i];
            WindowPix = wa[i];
            PixValid  = 1'b1;
            start_a   = pulse_start && (i == 1);
            tick();
        end
        PixValid = 1'b0;
        start_a  = 1'b0;
    endtask

    task automatic chk_emit_a(input int sad, input int erow, input int ecol);
        chk("emit_sadvalid", 32'(a_sad_valid), 1);
        chk("emit_pixready", 32'(a_pix_ready), 0);
        chk("emit_sadout",   a_sad_out, 32'(sad));
        chk("emit_rowout",   32'(a_row_out), 32'(erow));
        chk("emit_colout",   32'(a_col_out), 32'(ecol));
    endtask

    task automatic accept_a();
        sad_ready_a = 1'b1;
        tick();
        sad_ready_a = 1'b0;
    endtask

    task automatic set_const(input logic [7:0] f, input logic [7:0] w);
        for (int i = 0; i < 4; i++) begin
            fa[i] = f;
            wa[i] = w;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_b;

        // ---------------- Reset ----------------
        Rst = 1'b1;
        tick();
        tick();
        chk_reset_a();
        Rst = 1'b0;
        tick();
        chk("idle_pixready", 32'(a_pix_ready), 0);

        // ---------------- Full 2x3 scan ----------------
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_busy", 32'(a_busy), 1);

        for (int k = 0; k < 6; k++) begin
            set_const(8'd10, 8'(10 + k));
            // Start pulsed while busy in the third candidate must be ignored.
            feed_a(k / 3, k % 3, k == 2);
            chk_emit_a(4 * k, k / 3, k % 3);
            if (k == 1) begin
                // Backpressure with pixels offered: nothing may be consumed.
                PixValid  = 1'b1;
                FramePix  = 8'd0;
                WindowPix = 8'd255;
                for (int c = 0; c < 5; c++) begin
                    tick();
                    chk_emit_a(4, 0, 1);
                end
                PixValid = 1'b0;
            end
            accept_a();
            if (k < 5) begin
                chk("mid_done", 32'(a_done), 0);
                chk("mid_busy", 32'(a_busy), 1);
            end else begin
                chk("last_done", 32'(a_done), 1);
                chk("last_sadvalid", 32'(a_sad_valid), 0);
            end
        end
        tick();
        chk("after_done", 32'(a_done), 0);
        chk("after_busy", 32'(a_busy), 0);

        // ---------------- Abs diff both ways, then reset mid-scan ----------------
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        fa[0] = 8'd200; wa[0] = 8'd50;
        fa[1] = 8'd50;  wa[1] = 8'd200;
        fa[2] = 8'd200; wa[2] = 8'd50;
        fa[3] = 8'd50;  wa[3] = 8'd200;
        feed_a(0, 0, 1'b0);
        chk_emit_a(600, 0, 0);
        accept_a();
        set_const(8'd10, 8'd11);
        feed_a(0, 1, 1'b0);
        chk_emit_a(4, 0, 1);
        accept_a();
        // Third candidate: two pixels then reset.
        PixValid  = 1'b1;
        FramePix  = 8'd9;
        WindowPix = 8'd1;
        tick();
        tick();
        PixValid = 1'b0;
        chk("pre_rst_pixindex", 32'(a_pix_index), 2);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk_reset_a();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_done", 32'(a_done), 0);
            chk("post_rst_busy", 32'(a_busy), 0);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        set_const(8'd20, 8'd17);
        feed_a(0, 0, 1'b0);
        chk_emit_a(12, 0, 0);
        accept_a();
        // Return A to idle so it ignores the shared pixel bus from here on.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tick();

        // ---------------- Large sums: 16x16 (B) and 4x4 (C) ----------------
`ifdef SAD_SATURATE_EN
        exp_b = 32'd32767;
`else
        exp_b = 32'd65280;
`endif
        start_bc = 1'b1;
        tick();
        start_bc = 1'b0;
        chk("bc_busy_b", 32'(b_busy), 1);
        chk("bc_busy_c", 32'(c_busy), 1);
        chk("bc_idle_a", 32'(a_busy), 0);
        FramePix  = 8'd255;
        WindowPix = 8'd0;
        PixValid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
        end
        PixValid = 1'b0;
        chk("b_sadvalid", 32'(b_sad_valid), 1);
        chk("b_sadout",   b_sad_out, exp_b);
        chk("c_sadvalid", 32'(c_sad_valid), 1);
        chk("c_sadout",   c_sad_out, 32'd4080);
        chk("c_rowout",   32'(c_row_out), 0);
        chk("c_colout",   32'(c_col_out), 0);
        sad_ready_bc = 1'b1;
        tick();
        sad_ready_bc = 1'b0;
        chk("b_done", 32'(b_done), 1);
        chk("c_done", 32'(c_done), 1);
        tick();
        chk("b_done_clear", 32'(b_done), 0);
        chk("b_busy_clear", 32'(b_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
